// File: rtl/packet_buffer.sv
// Three-port word buffer between scheduler and hex display, drained on a periodic tick.
// Define BUFFER_DROP_COUNT_EN to build the saturating per-port drop counters.
module packet_buffer #(
  parameter int DEPTH    = 16,
  parameter int READ_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic        out_ram_wr1,
  input  logic        out_ram_wr2,
  input  logic        out_ram_wr3,
  input  logic [31:0] output1,
  input  logic [31:0] output2,
  input  logic [31:0] output3,
  output logic [7:0]  hex1,
  output logic [7:0]  hex2,
  output logic [7:0]  hex3,
  output logic [7:0]  hex4,
  output logic [7:0]  hex5,
  output logic [7:0]  hex6,
  output logic [7:0]  drop_cnt1,
  output logic [7:0]  drop_cnt2,
  output logic [7:0]  drop_cnt3
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (READ_DIV > 1) ? $clog2(READ_DIV) : 1;

  logic [CW-1:0] tick_cnt;
  logic          tick;

  assign tick = read_enable &&
                (tick_cnt == CW'(READ_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || !read_enable || tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  logic        wr  [3];
  logic [31:0] din [3];

  assign wr[0]  = out_ram_wr1;
  assign wr[1]  = out_ram_wr2;
  assign wr[2]  = out_ram_wr3;
  assign din[0] = output1;
  assign din[1] = output2;
  assign din[2] = output3;

  for (genvar p = 0; p < 3; p++) begin : g_port
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic [31:0]   head;
    logic [15:0]   disp;
    logic [7:0]    dcnt;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          unused_hi;

    assign empty     = (cnt == '0);
    assign full      = (cnt == (AW+1)'(DEPTH));
    assign pop       = tick && !empty;
    // A full FIFO still accepts a word when its head leaves on the same edge
    assign push      = write_enable && wr[p] && (!full || pop);
    assign head      = mem[rp];
    assign unused_hi = ^head[31:16];

    always_ff @(posedge clk) begin
      if (push && !reset)
        mem[wp] <= din[p];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wp   <= '0;
        rp   <= '0;
        cnt  <= '0;
        disp <= '0;
      end else begin
        if (push)
          wp <= wp + 1'b1;
        if (pop) begin
          rp   <= rp + 1'b1;
          disp <= head[15:0];
        end
        unique case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

`ifdef BUFFER_DROP_COUNT_EN
    logic drop_ev;

    assign drop_ev = write_enable && wr[p] &&
                     full && !pop;

    always_ff @(posedge clk) begin
      if (reset)
        dcnt <= '0;
      else if (drop_ev && dcnt != 8'hFF)
        dcnt <= dcnt + 1'b1;
    end
`else
    assign dcnt = '0;
`endif
  end

  assign hex1 = g_port[0].disp[15:8];
  assign hex2 = g_port[0].disp[7:0];
  assign hex3 = g_port[1].disp[15:8];
  assign hex4 = g_port[1].disp[7:0];
  assign hex5 = g_port[2].disp[15:8];
  assign hex6 = g_port[2].disp[7:0];

  assign drop_cnt1 = g_port[0].dcnt;
  assign drop_cnt2 = g_port[1].dcnt;
  assign drop_cnt3 = g_port[2].dcnt;

endmodule

// File: tb/tb_packet_buffer.sv
// Directed bench for packet_buffer with DEPTH=4, READ_DIV=4.
// Drop-count expectations follow BUFFER_DROP_COUNT_EN.
module tb_packet_buffer;

  logic        clk = 1'b0;
  logic        reset, write_enable, read_enable;
  logic        out_ram_wr1, out_ram_wr2, out_ram_wr3;
  logic [31:0] output1, output2, output3;
  logic [7:0]  hex1, hex2, hex3, hex4, hex5, hex6;
  logic [7:0]  drop_cnt1, drop_cnt2, drop_cnt3;

  int checks = 0;
  int errors = 0;

`ifdef BUFFER_DROP_COUNT_EN
  localparam logic [7:0] D = 8'd1;
`else
  localparam logic [7:0] D = 8'd0;
`endif

  always #5 clk = ~clk;

  packet_buffer #(.DEPTH(4), .READ_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .write_enable(write_enable),
    .read_enable(read_enable),
    .out_ram_wr1(out_ram_wr1),
    .out_ram_wr2(out_ram_wr2),
    .out_ram_wr3(out_ram_wr3),
    .output1(output1), .output2(output2),
    .output3(output3),
    .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .hex6(hex6),
    .drop_cnt1(drop_cnt1),
    .drop_cnt2(drop_cnt2),
    .drop_cnt3(drop_cnt3)
  );

  typedef struct {
    logic        rst, we, re;
    logic [2:0]  wr;
    logic [31:0] d1, d2, d3;
    logic [47:0] hex;
    logic [23:0] drop;
  } vec_t;

  vec_t vq[$];

  function automatic logic [47:0] hx(
      logic [15:0] a, logic [15:0] b, logic [15:0] c);
    return {a, b, c};
  endfunction

  task automatic add(logic rst, logic we, logic re,
      logic [2:0] wr, logic [31:0] d1, logic [31:0] d2,
      logic [31:0] d3, logic [47:0] hex, logic [23:0] drop);
    vec_t v;
    v.rst = rst; v.we = we; v.re = re; v.wr = wr;
    v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.hex = hex; v.drop = drop;
    vq.push_back(v);
  endtask

  task automatic drive(logic rst, logic we, logic re,
      logic [2:0] wr, logic [31:0] d1, logic [31:0] d2,
      logic [31:0] d3);
    reset = rst; write_enable = we; read_enable = re;
    out_ram_wr1 = wr[0]; out_ram_wr2 = wr[1];
    out_ram_wr3 = wr[2];
    output1 = d1; output2 = d2; output3 = d3;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [47:0] exp_hex,
      logic [23:0] exp_drop);
    logic [47:0] ah;
    logic [23:0] ad;
    ah = {hex1, hex2, hex3, hex4, hex5, hex6};
    ad = {drop_cnt1, drop_cnt2, drop_cnt3};
    checks++;
    if (ah !== exp_hex) begin
      errors++;
      $display("FAIL %s hex: got %h want %h", nm, ah, exp_hex);
    end
    checks++;
    if (ad !== exp_drop) begin
      errors++;
      $display("FAIL %s drop: got %h want %h", nm, ad, exp_drop);
    end
  endtask

  logic [47:0] h1;
  logic [15:0] b;
  logic [15:0] prev;

  initial begin
    drive(1, 0, 0, 3'b000, 0, 0, 0);
    h1 = hx(16'h1234, 16'h0, 16'h0);

    add(1, 0, 0, 3'b000, 0, 0, 0, 48'h0, 24'h0);
    add(1, 0, 0, 3'b000, 0, 0, 0, 48'h0, 24'h0);
    add(0, 1, 0, 3'b001, 32'h0000_1234, 0, 0, 48'h0, 24'h0);
    repeat (3) add(0, 0, 1, 3'b000, 0, 0, 0, 48'h0, 24'h0);
    add(0, 0, 1, 3'b000, 0, 0, 0, h1, 24'h0);
    add(0, 0, 1, 3'b010, 0, 32'hAAAA_5566, 0, h1, 24'h0);
    repeat (3) add(0, 0, 1, 3'b000, 0, 0, 0, h1, 24'h0);
    for (int i = 1; i <= 5; i++)
      add(0, 1, 0, 3'b100, 0, 0, 32'h0101 * i, h1,
          (i == 5) ? {16'h0, D} : 24'h0);
    prev = 16'h0;
    for (int k = 1; k <= 5; k++) begin
      b = (k <= 4) ? 16'h0101 * k : 16'h0404;
      repeat (3)
        add(0, 0, 1, 3'b000, 0, 0, 0,
            hx(16'h1234, 16'h0, prev), {16'h0, D});
      add(0, 0, 1, 3'b000, 0, 0, 0,
          hx(16'h1234, 16'h0, b), {16'h0, D});
      prev = b;
    end

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].we, vq[i].re, vq[i].wr,
            vq[i].d1, vq[i].d2, vq[i].d3);
      step();
      check($sformatf("vec%0d", i), vq[i].hex, vq[i].drop);
    end

    // Full port1 accepts a word on the edge its head pops
    drive(1, 0, 0, 3'b000, 0, 0, 0);
    step(); step();
    check("full_rst", 48'h0, 24'h0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 0, 3'b001, 32'h1111 * i, 0, 0);
      step();
    end
    drive(0, 0, 1, 3'b000, 0, 0, 0);
    repeat (3) step();
    drive(0, 1, 1, 3'b001, 32'h0909, 0, 0);
    step();
    check("full_tick_push", hx(16'h1111, 0, 0), 24'h0);
    drive(0, 1, 0, 3'b001, 32'hFFFF, 0, 0);
    step();
    check("full_after", hx(16'h1111, 0, 0), {D, 16'h0});
    drive(0, 0, 1, 3'b000, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: b = 16'h2222;
        1: b = 16'h3333;
        2: b = 16'h4444;
        default: b = 16'h0909;
      endcase
      repeat (4) step();
      check($sformatf("full_pop%0d", k), hx(b, 0, 0),
            {D, 16'h0});
    end

    // Reset in the middle of a tick period with data queued
    drive(1, 0, 0, 3'b000, 0, 0, 0);
    step(); step();
    check("mid_rst0", 48'h0, 24'h0);
    drive(0, 1, 0, 3'b110, 0, 32'h5555, 32'h6666);
    step();
    drive(0, 0, 1, 3'b000, 0, 0, 0);
    step(); step();
    drive(1, 1, 1, 3'b001, 32'h7777, 0, 0);
    step();
    check("mid_rst1", 48'h0, 24'h0);
    step();
    check("mid_rst2", 48'h0, 24'h0);
    drive(0, 0, 1, 3'b000, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("mid_post%0d", i), 48'h0, 24'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_buffer.md
PACKET_BUFFER -- requirements
Module: buffer

Interface
REQ-001 Parameter DEPTH, default 16: per-port FIFO depth in 32-bit words; power of two, >= 2.
REQ-002 Parameter READ_DIV, default 50_000_000: clock cycles between display pops while read_enable is high; >= 1.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 write_enable  input  1  level; capture of scheduler output words is allowed only while high.
REQ-006 read_enable  input  1  level; periodic popping to the display is allowed only while high.
REQ-007 out_ram_wr1, out_ram_wr2, out_ram_wr3  input  1 each  per-port word-valid strobe from the scheduler.
REQ-008 output1, output2, output3  input  32 each  per-port scheduler output word.
REQ-009 hex1..hex6  output  8 each  display bytes; port N drives hex(2N-1)=word[15:8] and hex(2N)=word[7:0].
REQ-010 drop_cnt1, drop_cnt2, drop_cnt3  output  8 each  per-port dropped-word count (see REQ-024).

Function
REQ-011 Each port N SHALL own an independent FIFO of DEPTH x 32 bits with read/write pointers, count, empty and full flags.
REQ-012 Push on port N SHALL occur at a clock edge when write_enable=1, out_ram_wrN=1 and the FIFO is not full, or is full and pops on the same edge.
REQ-013 A push attempted while write_enable=0 SHALL be ignored, with no state change.
REQ-014 A push attempted into a full FIFO with no same-edge pop SHALL be discarded and counted as a drop.
REQ-015 A tick counter SHALL increment each cycle read_enable=1, producing a one-cycle tick when it reaches READ_DIV-1, then wrap to 0.
REQ-016 The tick counter SHALL be held at 0 whenever read_enable=0; the first tick occurs READ_DIV cycles after read_enable rises.
REQ-017 On a tick, each non-empty FIFO SHALL pop its head word, and the port's hex pair SHALL load that word's bytes on the same edge.
REQ-018 On a tick, an empty FIFO SHALL NOT pop, and its hex pair SHALL hold its previous value.
REQ-019 Simultaneous push and pop on one port SHALL leave the count unchanged; pushing into an empty FIFO on a tick edge SHALL NOT be popped on that edge.
REQ-020 Pointers SHALL wrap modulo DEPTH; words SHALL pop in strict push order per port.
REQ-021 Ports SHALL be fully independent; activity on one port never alters another port's FIFO, hex pair or drop count.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 On reset, all FIFOs SHALL empty (pointers and counts 0), the tick counter SHALL be 0, hex1..hex6 SHALL be 0x00 and drop_cnt1..3 SHALL be 0; reset overrides any same-cycle push or pop, including mid-operation.

Configuration
REQ-024 With BUFFER_DROP_COUNT_EN defined, drop_cntN SHALL increment by 1 per discarded word (REQ-014), saturating at 0xFF; without the macro, drop_cnt1..3 SHALL be constant 0 and no counter logic SHALL exist.

Verification (DEPTH=4, READ_DIV=4, BUFFER_DROP_COUNT_EN defined unless noted)
REQ-025 Assert reset 2 cycles -> hex1..hex6=0x00, drop_cnt1..3=0, all FIFOs empty.
REQ-026 write_enable=1, out_ram_wr1=1 with output1=0x0000_1234 for 1 cycle, then read_enable=1 -> after 4 cycles hex1=0x12, hex2=0x34, hex3..hex6 remain 0x00.
REQ-027 write_enable=0, out_ram_wr2 pulsed with output2=0xAAAA_5566, read_enable=1 -> no tick changes hex3/hex4 (stay 0x00).
REQ-028 Push 5 words 0x0101, 0x0202, 0x0303, 0x0404, 0x0505 to port3 back-to-back -> drop_cnt3=1; successive ticks show hex5/hex6 = 01/01, 02/02, 03/03, 04/04, then hold 04/04; without the macro drop_cnt3 stays 0.
REQ-029 Port1 full, push 0x0909 on the tick edge -> head popped, 0x0909 stored, count remains 4, no drop.
REQ-030 Reset asserted 2 cycles into READ_DIV with data queued -> all outputs 0, FIFOs empty, the next tick after read_enable reasserts shows no data.
